mips_wb_arb: RTL and testbench

Write-back arbiter and result formatter that drives the single register-file write port (wb_dest_en / wb_dest_idx / wb_dest_dat). It merges two result sources into one registered write per cycle:
- in-order MEM/WB pipeline results, with load-data extraction;
- results from the multi-cycle mul/div unit, buffered in a small FIFO.

It also publishes a pending-destination vector for hazard detection in ID.

---
 rtl/mips_wb_arb.sv | 180 ++++++++++++++++++
 tb/tb_mips_wb_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_wb_arb.sv
// ============================================================================
// Module   : mips_wb_arb
// Purpose  : Write-back arbiter merging MEM/WB results and a buffered mul/div
//            result FIFO onto the single register-file write port.
// Revision : 1.0  initial release
// ============================================================================
`ifndef MIPS_RFIDX_WIDTH
`define MIPS_RFIDX_WIDTH 5
`endif
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif
`ifndef MIPS_RFREG_NUM
`define MIPS_RFREG_NUM 32
`endif

`default_nettype none

module mips_wb_arb #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pl_valid,
    input  logic                          pl_dest_en,
    input  logic [`MIPS_RFIDX_WIDTH-1:0]  pl_dest_idx,
    input  logic                          pl_is_load,
    input  logic [1:0]                    pl_ld_size,
    input  logic                          pl_ld_uns,
    input  logic [1:0]                    pl_addr_lo,
    input  logic [`MIPS_DATA_WIDTH-1:0]   pl_alu_dat,
    input  logic [`MIPS_DATA_WIDTH-1:0]   pl_ld_dat,
    input  logic                          md_valid,
    output logic                          md_ready,
    input  logic [`MIPS_RFIDX_WIDTH-1:0]  md_idx,
    input  logic [`MIPS_DATA_WIDTH-1:0]   md_dat,
    output logic                          wb_stall,
    output logic [`MIPS_RFREG_NUM-1:0]    md_pend,
    output logic                          wb_dest_en,
    output logic [`MIPS_RFIDX_WIDTH-1:0]  wb_dest_idx,
    output logic [`MIPS_DATA_WIDTH-1:0]   wb_dest_dat
);

    localparam int c_iw    = `MIPS_RFIDX_WIDTH;
    localparam int c_dw    = `MIPS_DATA_WIDTH;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_stv_w = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    logic [c_iw-1:0]     r_idx_mem [FIFO_DEPTH];
    logic [c_dw-1:0]     r_dat_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_stv_w-1:0]  r_starve;
    logic                r_stall;
    logic                r_en;
    logic [c_iw-1:0]     r_idx;
    logic [c_dw-1:0]     r_dat;

    logic                w_pl_req;
    logic                w_nonempty;
    logic                w_pop;
    logic                w_push;
    logic                w_wait;
    logic                w_starve_hit;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [c_dw-1:0]     w_ld_fmt;
    logic [c_dw-1:0]     w_pl_dat;
    logic [FIFO_DEPTH-1:0]        w_slot_vld;
    logic [`MIPS_RFREG_NUM-1:0]   w_md_pend;

    assign w_pl_req   = pl_valid & pl_dest_en & (pl_dest_idx != '0) & ~r_stall;
    assign w_nonempty = (r_count != '0);
    // A stall cycle always has a non-empty FIFO, so the head wins whenever
    // the pipeline is not requesting.
    assign w_pop      = w_nonempty & ~w_pl_req;
    assign md_ready   = (r_count < c_cnt_w'(FIFO_DEPTH));
    assign w_push     = md_valid & md_ready & (md_idx != '0);

    assign w_wait       = w_nonempty & ~w_pop;
    assign w_starve_hit = w_wait & (r_starve == c_stv_w'(STARVE_LIMIT - 1));

    // Big-endian lanes: address 0 selects the most significant byte.
    always_comb begin
        w_byte   = 8'h00;
        w_half   = 16'h0000;
        w_ld_fmt = pl_ld_dat;
        case (pl_addr_lo)
            2'd0:    w_byte = pl_ld_dat[31:24];
            2'd1:    w_byte = pl_ld_dat[23:16];
            2'd2:    w_byte = pl_ld_dat[15:8];
            default: w_byte = pl_ld_dat[7:0];
        endcase
        w_half = pl_addr_lo[1] ? pl_ld_dat[15:0] : pl_ld_dat[31:16];
        case (pl_ld_size)
            2'b00:   w_ld_fmt = {{(c_dw-8){~pl_ld_uns & w_byte[7]}}, w_byte};
            2'b01:   w_ld_fmt = {{(c_dw-16){~pl_ld_uns & w_half[15]}}, w_half};
            default: w_ld_fmt = pl_ld_dat;
        endcase
    end

    assign w_pl_dat = pl_is_load ? w_ld_fmt : pl_alu_dat;

    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_slot
        logic [c_ptr_w-1:0] w_off;
        assign w_off         = c_ptr_w'(i) - r_rd_ptr;
        assign w_slot_vld[i] = (c_cnt_w'(w_off) < r_count);
    end

    always_comb begin
        w_md_pend = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_slot_vld[i]) begin
                w_md_pend[r_idx_mem[i]] = 1'b1;
            end
        end
    end

    assign md_pend = w_md_pend;

    // Storage needs no reset: occupancy is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_idx_mem[r_wr_ptr] <= md_idx;
            r_dat_mem[r_wr_ptr] <= md_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
            r_en     <= 1'b0;
            r_idx    <= '0;
            r_dat    <= '0;
        end else begin
            r_en <= w_pl_req | w_pop;
            if (w_pl_req) begin
                r_idx <= pl_dest_idx;
                r_dat <= w_pl_dat;
            end else if (w_pop) begin
                r_idx <= r_idx_mem[r_rd_ptr];
                r_dat <= r_dat_mem[r_rd_ptr];
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase

            r_stall <= w_starve_hit;
            if (w_wait && !w_starve_hit) begin
                r_starve <= r_starve + c_stv_w'(1);
            end else begin
                r_starve <= '0;
            end
        end
    end

    assign wb_stall    = r_stall;
    assign wb_dest_en  = r_en;
    assign wb_dest_idx = r_idx;
    assign wb_dest_dat = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_mips_wb_arb.sv
// ============================================================================
// Module   : tb_mips_wb_arb
// Purpose  : Self-checking bench for mips_wb_arb against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
`ifndef MIPS_RFIDX_WIDTH
`define MIPS_RFIDX_WIDTH 5
`endif
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif
`ifndef MIPS_RFREG_NUM
`define MIPS_RFREG_NUM 32
`endif

`default_nettype none

module tb_mips_wb_arb;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pl_valid, pl_dest_en, pl_is_load, pl_ld_uns;
    logic [4:0]  pl_dest_idx;
    logic [1:0]  pl_ld_size, pl_addr_lo;
    logic [31:0] pl_alu_dat, pl_ld_dat;
    logic        md_valid, md_ready;
    logic [4:0]  md_idx;
    logic [31:0] md_dat;
    logic        wb_stall, wb_dest_en;
    logic [31:0] md_pend;
    logic [4:0]  wb_dest_idx;
    logic [31:0] wb_dest_dat;

    always #5 clk = ~clk;

    mips_wb_arb #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pl_valid(pl_valid), .pl_dest_en(pl_dest_en), .pl_dest_idx(pl_dest_idx),
        .pl_is_load(pl_is_load), .pl_ld_size(pl_ld_size), .pl_ld_uns(pl_ld_uns),
        .pl_addr_lo(pl_addr_lo), .pl_alu_dat(pl_alu_dat), .pl_ld_dat(pl_ld_dat),
        .md_valid(md_valid), .md_ready(md_ready), .md_idx(md_idx), .md_dat(md_dat),
        .wb_stall(wb_stall), .md_pend(md_pend),
        .wb_dest_en(wb_dest_en), .wb_dest_idx(wb_dest_idx), .wb_dest_dat(wb_dest_dat)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: the FIFO as a queue plus the visible outputs.
    logic [4:0]  q_idx[$];
    logic [31:0] q_dat[$];
    int          m_starve;
    bit          m_stall;
    bit          m_en;
    logic [4:0]  m_idx;
    logic [31:0] m_dat;

    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] sz,
                                             input logic [1:0] a, input logic uns);
        int          sh;
        logic [31:0] v;
        if (sz == 2'b00) begin
            sh = (3 - int'(a)) * 8;
            v  = (d >> sh) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = a[1] ? 0 : 16;
            v  = (d >> sh) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_pend();
        logic [31:0] p = '0;
        foreach (q_idx[i]) p[q_idx[i]] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        q_idx.delete();
        q_dat.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        m_en     = 1'b0;
        m_idx    = '0;
        m_dat    = '0;
    endtask

    // One clock of the specification's rules applied to the current inputs.
    task automatic model_step();
        int  size0  = q_idx.size();
        bit  popped = 1'b0;
        bit  req    = pl_valid && pl_dest_en && (pl_dest_idx != 0) && !m_stall;
        if (req) begin
            m_en  = 1'b1;
            m_idx = pl_dest_idx;
            m_dat = pl_is_load ? ref_load(pl_ld_dat, pl_ld_size, pl_addr_lo, pl_ld_uns) : pl_alu_dat;
        end else if (size0 > 0) begin
            m_en  = 1'b1;
            m_idx = q_idx.pop_front();
            m_dat = q_dat.pop_front();
            popped = 1'b1;
        end else begin
            m_en = 1'b0;
        end
        if (md_valid && size0 < DEPTH && md_idx != 0) begin
            q_idx.push_back(md_idx);
            q_dat.push_back(md_dat);
        end
        m_stall = 1'b0;
        if (size0 > 0 && !popped) begin
            m_starve++;
            if (m_starve == LIMIT) begin
                m_stall  = 1'b1;
                m_starve = 0;
            end
        end else begin
            m_starve = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pl_valid = 0; pl_dest_en = 0; pl_dest_idx = 0; pl_is_load = 0;
        pl_ld_size = 0; pl_ld_uns = 0; pl_addr_lo = 0; pl_alu_dat = 0; pl_ld_dat = 0;
        md_valid = 0; md_idx = 0; md_dat = 0;
    endtask

    task automatic set_alu(input logic [4:0] idx, input logic [31:0] d);
        pl_valid = 1; pl_dest_en = 1; pl_dest_idx = idx; pl_is_load = 0; pl_alu_dat = d;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pend;
        n_cmp++;
        if ({wb_dest_en, wb_dest_idx, wb_dest_dat, wb_stall, md_ready, md_pend} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0}) begin
            n_err++;
            $display("FAIL reset_state: got en=%b idx=%0d dat=%h stall=%b rdy=%b pend=%h, want 0/0/0/0/1/0",
                     wb_dest_en, wb_dest_idx, wb_dest_dat, wb_stall, md_ready, md_pend);
        end
        rst = 0;
        model_reset();
        set_alu(5'd1, 32'h11);
        md_valid = 1; md_idx = 5; md_dat = 32'h55; tick();
        md_idx = 6; md_dat = 32'h66; tick();
        idle_inputs();
        exp_pend = 32'h0000_0060;
        n_cmp++;
        if (md_pend !== exp_pend || md_ready !== 1'b0) begin
            n_err++;
            $display("FAIL pend_before_reset: got pend=%h rdy=%b, want %h rdy=0", md_pend, md_ready, exp_pend);
        end
        #3 rst = 1;
        #1;
        n_cmp++;
        if (md_pend !== 32'd0 || md_ready !== 1'b1 || wb_dest_en !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got pend=%h rdy=%b en=%b, want 0/1/0", md_pend, md_ready, wb_dest_en);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (wb_dest_en !== 1'b0) begin
                n_err++;
                $display("FAIL no_write_after_reset: got en=%b idx=%0d, want en=0", wb_dest_en, wb_dest_idx);
            end
        end
    endtask

    task automatic test_load_formats();
        logic [1:0]  sz [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        logic [1:0]  ad [5] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd1};
        logic        un [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] ex [5] = '{32'hFFFF_FF80, 32'h0000_0022, 32'h0000_7F22, 32'hFFFF_80F1, 32'h80F1_7F22};
        for (int i = 0; i < 5; i++) begin
            pl_valid = 1; pl_dest_en = 1; pl_dest_idx = 3; pl_is_load = 1;
            pl_ld_dat = 32'h80F1_7F22; pl_ld_size = sz[i]; pl_addr_lo = ad[i]; pl_ld_uns = un[i];
            pl_alu_dat = 32'hDEAD_BEEF;
            tick();
            n_cmp++;
            if (wb_dest_en !== 1'b1 || wb_dest_idx !== 5'd3 || wb_dest_dat !== ex[i]) begin
                n_err++;
                $display("FAIL load_fmt_%0d: got en=%b idx=%0d dat=%h, want 1/3/%h", i, wb_dest_en, wb_dest_idx, wb_dest_dat, ex[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            pl_ld_dat = $urandom; pl_ld_size = 2'($urandom); pl_addr_lo = 2'($urandom);
            pl_ld_uns = 1'($urandom); pl_dest_idx = 5'($urandom_range(1, 31));
            tick();
            n_cmp++;
            if (wb_dest_dat !== m_dat || wb_dest_idx !== m_idx) begin
                n_err++;
                $display("FAIL load_rand: got idx=%0d dat=%h, want %0d/%h", wb_dest_idx, wb_dest_dat, m_idx, m_dat);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_priority_starve();
        logic [31:0] wd [5];
        set_alu(5'd2, 32'hA0);
        md_valid = 1; md_idx = 7; md_dat = 32'h1234;
        tick();
        md_valid = 0;
        for (int k = 0; k < 4; k++) begin
            pl_alu_dat = 32'hA1 + k;
            tick();
            n_cmp++;
            if (wb_dest_en !== 1'b1 || wb_dest_idx !== 5'd2 || wb_dest_dat !== 32'hA1 + k || wb_stall !== (k == 3)) begin
                n_err++;
                $display("FAIL pl_priority_%0d: got en=%b idx=%0d dat=%h stall=%b, want 1/2/%h/%b",
                         k, wb_dest_en, wb_dest_idx, wb_dest_dat, wb_stall, 32'hA1 + k, (k == 3));
            end
        end
        pl_alu_dat = 32'hA5;
        tick();
        n_cmp++;
        if (wb_dest_en !== 1'b1 || wb_dest_idx !== 5'd7 || wb_dest_dat !== 32'h1234 || wb_stall !== 1'b0) begin
            n_err++;
            $display("FAIL forced_drain: got en=%b idx=%0d dat=%h stall=%b, want 1/7/00001234/0", wb_dest_en, wb_dest_idx, wb_dest_dat, wb_stall);
        end
        tick();
        n_cmp++;
        if (wb_dest_idx !== 5'd2 || wb_dest_dat !== 32'hA5) begin
            n_err++;
            $display("FAIL held_after_stall: got idx=%0d dat=%h, want 2/000000a5", wb_dest_idx, wb_dest_dat);
        end
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            if (k < 5) begin
                wd[k] = $urandom;
                md_valid = 1; md_idx = 5'(10 + k); md_dat = wd[k];
            end else begin
                md_valid = 0;
            end
            tick();
            if (k > 0) begin
                n_cmp++;
                if (wb_dest_en !== 1'b1 || wb_dest_idx !== 5'(9 + k) || wb_dest_dat !== wd[k-1]) begin
                    n_err++;
                    $display("FAIL wrap_%0d: got en=%b idx=%0d dat=%h, want 1/%0d/%h", k, wb_dest_en, wb_dest_idx, wb_dest_dat, 9 + k, wd[k-1]);
                end
            end
        end
        tick();
    endtask

    task automatic test_full_fifo();
        set_alu(5'd4, 32'h44);
        md_valid = 1; md_idx = 8; md_dat = 32'h88; tick();
        md_idx = 9; md_dat = 32'h99; tick();
        md_idx = 10; md_dat = 32'hAA;
        n_cmp++;
        if (md_ready !== 1'b0 || md_pend !== 32'h0000_0300) begin
            n_err++;
            $display("FAIL full_ready: got rdy=%b pend=%h, want 0/00000300", md_ready, md_pend);
        end
        for (int k = 0; k < 4; k++) tick();
        n_cmp++;
        if (md_ready !== 1'b1 || md_pend !== 32'h0000_0200) begin
            n_err++;
            $display("FAIL no_third_push: got rdy=%b pend=%h, want 1/00000200", md_ready, md_pend);
        end
        tick();
        n_cmp++;
        if (md_pend !== 32'h0000_0600) begin
            n_err++;
            $display("FAIL third_push: got pend=%h, want 00000600", md_pend);
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if ({wb_dest_en, wb_dest_idx, wb_dest_dat, md_pend} !== {m_en, m_idx, m_dat, model_pend()}) begin
                n_err++;
                $display("FAIL full_drain_%0d: got en=%b idx=%0d dat=%h pend=%h, want %b/%0d/%h/%h",
                         k, wb_dest_en, wb_dest_idx, wb_dest_dat, md_pend, m_en, m_idx, m_dat, model_pend());
            end
        end
    endtask

    task automatic test_zero_idx();
        pl_valid = 1; pl_dest_en = 1; pl_dest_idx = 0; pl_alu_dat = 32'h77;
        md_valid = 1; md_idx = 0; md_dat = 32'h66;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (wb_dest_en !== 1'b0 || md_pend !== 32'd0 || md_ready !== 1'b1) begin
                n_err++;
                $display("FAIL zero_idx_%0d: got en=%b pend=%h rdy=%b, want 0/0/1", k, wb_dest_en, md_pend, md_ready);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (!m_stall) begin
                pl_valid = 1'($urandom); pl_dest_en = ($urandom_range(0, 3) != 0);
                pl_dest_idx = 5'($urandom_range(0, 7)); pl_is_load = 1'($urandom);
                pl_ld_size = 2'($urandom); pl_ld_uns = 1'($urandom); pl_addr_lo = 2'($urandom);
                pl_alu_dat = $urandom; pl_ld_dat = $urandom;
            end
            md_valid = ($urandom_range(0, 2) == 0); md_idx = 5'($urandom_range(0, 7)); md_dat = $urandom;
            tick();
            n_cmp++;
            if ({wb_dest_en, wb_dest_idx, wb_dest_dat, wb_stall, md_ready, md_pend} !==
                {m_en, m_idx, m_dat, m_stall, (q_idx.size() < DEPTH), model_pend()}) begin
                n_err++;
                $display("FAIL random_%0d: got en=%b idx=%0d dat=%h stall=%b rdy=%b pend=%h, want %b/%0d/%h/%b/%b/%h",
                         c, wb_dest_en, wb_dest_idx, wb_dest_dat, wb_stall, md_ready, md_pend,
                         m_en, m_idx, m_dat, m_stall, (q_idx.size() < DEPTH), model_pend());
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_formats();
        test_priority_starve();
        test_full_fifo();
        test_zero_idx();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
